// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier.
// Each RUN cycle adds the multiplicand shifted left by the current bit index
// into the accumulator when the matching multiplier bit is set. Latency is a
// fixed WIDTH cycles. A new operation may start in the DONE cycle.
module shift_add_multiplier #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int IDX_W = $clog2(WIDTH) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   logic [1:0]           state_reg,   state_next;
   logic [2*WIDTH-1:0]   a_ext_reg,   a_ext_next;
   logic [WIDTH-1:0]     b_reg,       b_next;
   logic [2*WIDTH-1:0]   acc_reg,     acc_next;
   logic [IDX_W-1:0]     index_reg,   index_next;
   logic [2*WIDTH-1:0]   product_reg, product_next;

   logic [2*WIDTH-1:0]   shifted_a;
   logic [2*WIDTH-1:0]   partial;
   logic [2*WIDTH-1:0]   acc_sum;
   logic                 cur_bit;

   // The top index bit is only set once the counter would run past the
   // operand, which never happens inside RUN, so the low bits select B.
   assign cur_bit   = b_reg[index_reg[IDX_W-2:0]];
   assign shifted_a = a_ext_reg << index_reg;
   assign partial   = cur_bit ? shifted_a : '0;
   assign acc_sum   = acc_reg + partial;

   assign busy    = (state_reg == RUN);
   assign done    = (state_reg == DONE);
   assign product = product_reg;

   // Next-state and datapath update selection for the three-state controller
   always_comb begin
      state_next   = state_reg;
      a_ext_next   = a_ext_reg;
      b_next       = b_reg;
      acc_next     = acc_reg;
      index_next   = index_reg;
      product_next = product_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = RUN;
               a_ext_next = {{WIDTH{1'b0}}, multiplicand};
               b_next     = multiplier;
               acc_next   = '0;
               index_next = '0;
            end
         end
         RUN: begin
            acc_next   = acc_sum;
            index_next = index_reg + IDX_ONE;
            if (index_reg == LAST_IDX) begin
               // Final partial product goes straight into the result so the
               // product is valid in the same cycle done is raised.
               state_next   = DONE;
               product_next = acc_sum;
            end
         end
         DONE: begin
            if (start) begin
               state_next = RUN;
               a_ext_next = {{WIDTH{1'b0}}, multiplicand};
               b_next     = multiplier;
               acc_next   = '0;
               index_next = '0;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State and datapath registers; reset wins over any start request
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         a_ext_reg   <= '0;
         b_reg       <= '0;
         acc_reg     <= '0;
         index_reg   <= '0;
         product_reg <= '0;
      end else begin
         state_reg   <= state_next;
         a_ext_reg   <= a_ext_next;
         b_reg       <= b_next;
         acc_reg     <= acc_next;
         index_reg   <= index_next;
         product_reg <= product_next;
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: scenario tasks drive
// operations and check timing inline; a monitor pops the expected product
// queue on every done pulse.
module tb_shift_add_multiplier;

   localparam int WIDTH = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic [WIDTH-1:0]     multiplicand = '0;
   logic [WIDTH-1:0]     multiplier = '0;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   int checks = 0;
   int errors = 0;
   int done_pulses = 0;
   int cyc = 0;
   logic [2*WIDTH-1:0] sb[$];

   shift_add_multiplier #(.WIDTH(WIDTH)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .multiplicand(multiplicand),
      .multiplier(multiplier),
      .busy(busy),
      .done(done),
      .product(product)
   );

   always #5 clk = ~clk;

   // Rising-edge counter used to measure latency
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every done pulse consumes one expected product
   always @(negedge clk) begin
      logic [2*WIDTH-1:0] exp_p;
      if (done === 1'b1) begin
         done_pulses++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done product=%h expected no pulse", product);
         end else begin
            exp_p = sb.pop_front();
            $display("done: product=%h expected=%h", product, exp_p);
            if (product !== exp_p) begin
               errors++;
               $display("FAIL product got=%h exp=%h", product, exp_p);
            end
         end
      end
      if (busy === 1'b1 && done === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL busy_done_overlap busy=%b done=%b exp not both", busy, done);
      end
   end

   // Wait (bounded) until done is seen at a falling edge; count busy cycles
   task automatic wait_done(output int busy_n);
      int guard;
      busy_n = 0;
      guard = 0;
      while (done !== 1'b1 && guard < 100) begin
         if (busy === 1'b1) busy_n++;
         @(negedge clk);
         guard++;
      end
      if (done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL done_timeout done=%b exp 1 within 100 cycles", done);
      end
   endtask

   // One complete operation from idle with latency and busy-length checks
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string name);
      int e0, busy_n, lat;
      @(negedge clk);
      start = 1'b1;
      multiplicand = a;
      multiplier = b;
      sb.push_back(32'(a) * 32'(b));
      @(negedge clk);
      start = 1'b0;
      multiplicand = WIDTH'($urandom);
      multiplier = WIDTH'($urandom);
      e0 = cyc;
      wait_done(busy_n);
      lat = cyc - e0;
      $display("%s: a=%h b=%h latency=%0d busy_cycles=%0d", name, a, b, lat, busy_n);
      checks++;
      if (lat != WIDTH) begin
         errors++;
         $display("FAIL %s_latency got=%0d exp=%0d", name, lat, WIDTH);
      end
      checks++;
      if (busy_n != WIDTH) begin
         errors++;
         $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, busy_n, WIDTH);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL %s_done_one_cycle got=%b exp=0", name, done);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      $display("reset: busy=%b done=%b product=%h", busy, done, product);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++;
      if (product !== 32'h0) begin errors++; $display("FAIL reset_product got=%h exp=0", product); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset busy=%b done=%b exp 0 0", busy, done);
      end
   endtask

   task automatic test_basic();
      run_op(16'd3, 16'd5, "basic");
   endtask

   task automatic test_max();
      run_op(16'hFFFF, 16'hFFFF, "max");
   endtask

   task automatic test_boundary();
      run_op(16'h8000, 16'h8000, "msb");
      run_op(16'h0000, 16'h1234, "zero_a");
      run_op(16'h1234, 16'h0001, "b_one");
      for (int i = 0; i < 3; i++) begin
         run_op(WIDTH'($urandom), WIDTH'($urandom), "random");
      end
   endtask

   task automatic test_ignore_hold();
      int e0, busy_n, lat, dp0;
      @(negedge clk);
      start = 1'b1;
      multiplicand = 16'd7;
      multiplier = 16'd9;
      sb.push_back(32'h0000003F);
      @(negedge clk);
      start = 1'b0;
      multiplicand = 16'hFFFF;
      multiplier = 16'hFFFF;
      e0 = cyc;
      dp0 = done_pulses;
      repeat (4) @(negedge clk);
      start = 1'b1;
      multiplicand = 16'd1;
      multiplier = 16'd1;
      @(negedge clk);
      start = 1'b0;
      multiplicand = 16'hA5A5;
      wait_done(busy_n);
      lat = cyc - e0;
      $display("ignore: latency=%0d product=%h", lat, product);
      checks++;
      if (lat != WIDTH) begin
         errors++;
         $display("FAIL ignore_latency got=%0d exp=%0d", lat, WIDTH);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (product !== 32'h0000003F || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle product=%h busy=%b exp 0000003f 0", product, busy);
         end
      end
      checks++;
      if (done_pulses - dp0 != 1) begin
         errors++;
         $display("FAIL ignore_pulse_count got=%0d exp=1", done_pulses - dp0);
      end
   endtask

   task automatic test_back_to_back();
      int e0, busy_n, lat;
      @(negedge clk);
      start = 1'b1;
      multiplicand = 16'd4;
      multiplier = 16'd4;
      sb.push_back(32'h00000010);
      @(negedge clk);
      start = 1'b0;
      wait_done(busy_n);
      checks++;
      if (product !== 32'h00000010) begin
         errors++;
         $display("FAIL b2b_first product=%h exp=00000010", product);
      end
      // Request the next operation during the done cycle
      start = 1'b1;
      multiplicand = 16'd2;
      multiplier = 16'd3;
      sb.push_back(32'h00000006);
      @(negedge clk);
      start = 1'b0;
      multiplicand = 16'h7777;
      multiplier = 16'h7777;
      e0 = cyc;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_restart busy=%b done=%b exp 1 0", busy, done);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (product !== 32'h00000010) begin
            errors++;
            $display("FAIL b2b_hold product=%h exp=00000010", product);
         end
         @(negedge clk);
      end
      wait_done(busy_n);
      lat = cyc - e0;
      $display("b2b: second latency=%0d product=%h", lat, product);
      checks++;
      if (lat != WIDTH) begin
         errors++;
         $display("FAIL b2b_latency got=%0d exp=%0d", lat, WIDTH);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int dp0;
      @(negedge clk);
      start = 1'b1;
      multiplicand = 16'd10;
      multiplier = 16'd10;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_busy_before got=%b exp=1", busy);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      $display("abort: busy=%b done=%b product=%h", busy, done, product);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
         errors++;
         $display("FAIL abort_state busy=%b done=%b product=%h exp 0 0 00000000",
                  busy, done, product);
      end
      dp0 = done_pulses;
      repeat (25) @(negedge clk);
      checks++;
      if (done_pulses != dp0) begin
         errors++;
         $display("FAIL abort_no_done got=%0d pulses exp=0", done_pulses - dp0);
      end
      run_op(16'd10, 16'd10, "after_abort");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max();
      test_boundary();
      test_ignore_hold();
      test_back_to_back();
      test_reset_mid();
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
